// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, grant
// identifiers and the write payload carried to the RAM write port.
package dmem_arbiter_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_CPU  = 2'd1,
    ST_RD_HOST = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_CPU  = 1'b0,
    GRANT_HOST = 1'b1
  } grant_e;

  typedef struct packed {
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } wr_payload_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant (bit 0 = CPU, bit 1 = host).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   req_i[1:0]  : request vector
//   advance_i   : arbitration point; a grant here updates last_grant
//   gnt_o_c     : one-hot combinational grant
module rr_arb2
  import dmem_arbiter_pkg::*;
#(
  parameter bit FIXED_CPU_PRI = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o_c
);

  grant_e last_q, last_d;

  // Tie goes to whoever did not win last time, or always to the CPU.
  always_comb begin
    gnt_o_c = 2'b00;
    last_d  = last_q;
    case (req_i)
      2'b01:   gnt_o_c = 2'b01;
      2'b10:   gnt_o_c = 2'b10;
      2'b11:   gnt_o_c = (FIXED_CPU_PRI || (last_q == GRANT_HOST)) ? 2'b01 : 2'b10;
      default: gnt_o_c = 2'b00;
    endcase
    if (advance_i && gnt_o_c[0]) begin
      last_d = GRANT_CPU;
    end else if (advance_i && gnt_o_c[1]) begin
      last_d = GRANT_HOST;
    end
  end

  // Reset to HOST so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GRANT_HOST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port-pair data RAM between the CPU data port and the
// host CSR window with Avalon-style waitrequest handshakes.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cpu_*                      : CPU byte-addressed Avalon slave (read/write)
//   host_*                     : host word-addressed Avalon slave (read/write)
//   mem_wren/byteena/wraddress/data : RAM write port (combinational)
//   mem_rdaddress / mem_q      : RAM read port, q valid one cycle after address
// Writes complete in the granting cycle; reads take two cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 12,
  parameter bit          FIXED_CPU_PRI = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cpu_address,
  input  logic                  cpu_write,
  input  logic [31:0]           cpu_writedata,
  input  logic [3:0]            cpu_byteenable,
  input  logic                  cpu_read,
  output logic [31:0]           cpu_readdata,
  output logic                  cpu_waitrequest,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic                  host_write,
  input  logic [31:0]           host_writedata,
  input  logic                  host_read,
  output logic [31:0]           host_readdata,
  output logic                  host_waitrequest,
  output logic                  mem_wren,
  output logic [3:0]            mem_byteena,
  output logic [ADDR_WIDTH-1:0] mem_wraddress,
  output logic [31:0]           mem_data,
  output logic [ADDR_WIDTH-1:0] mem_rdaddress,
  input  logic [31:0]           mem_q
);

  localparam int unsigned AW = ADDR_WIDTH;

  state_e          state_q, state_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [AW-1:0]   cpu_word;
  logic [1:0]      req, gnt;
  wr_payload_t     cpu_wr, host_wr;
  logic            unused_cpu_addr_bits;

  // CPU byte address -> word index; upper bits alias, low bits ignored.
  assign cpu_word             = cpu_address[AW+1:2];
  assign unused_cpu_addr_bits = ^{cpu_address[31:AW+2], cpu_address[1:0]};

  assign cpu_wr  = '{be: cpu_byteenable, data: cpu_writedata};
  assign host_wr = '{be: 4'hF, data: host_writedata};
  assign req     = {host_read | host_write, cpu_read | cpu_write};

  rr_arb2 #(
    .FIXED_CPU_PRI(FIXED_CPU_PRI)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req),
    .advance_i(state_q == ST_IDLE),
    .gnt_o_c  (gnt)
  );

  // Next state and RAM/requester muxing; everything idles while reset is high.
  always_comb begin
    state_d          = state_q;
    rd_addr_d        = rd_addr_q;
    cpu_waitrequest  = 1'b1;
    host_waitrequest = 1'b1;
    cpu_readdata     = 32'h0;
    host_readdata    = 32'h0;
    mem_wren         = 1'b0;
    mem_byteena      = 4'h0;
    mem_wraddress    = '0;
    mem_data         = 32'h0;
    mem_rdaddress    = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          if (gnt[0]) begin
            if (cpu_write) begin
              mem_wren        = 1'b1;
              mem_byteena     = cpu_wr.be;
              mem_wraddress   = cpu_word;
              mem_data        = cpu_wr.data;
              cpu_waitrequest = 1'b0;
            end else begin
              mem_rdaddress = cpu_word;
              rd_addr_d     = cpu_word;
              state_d       = ST_RD_CPU;
            end
          end else if (gnt[1]) begin
            if (host_write) begin
              mem_wren         = 1'b1;
              mem_byteena      = host_wr.be;
              mem_wraddress    = host_address;
              mem_data         = host_wr.data;
              host_waitrequest = 1'b0;
            end else begin
              mem_rdaddress = host_address;
              rd_addr_d     = host_address;
              state_d       = ST_RD_HOST;
            end
          end
        end
        ST_RD_CPU: begin
          mem_rdaddress   = rd_addr_q;
          cpu_waitrequest = 1'b0;
          cpu_readdata    = mem_q;
          state_d         = ST_IDLE;
        end
        ST_RD_HOST: begin
          mem_rdaddress    = rd_addr_q;
          host_waitrequest = 1'b0;
          host_readdata    = mem_q;
          state_d          = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and captured read address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a round-robin instance (index 0) and a fixed-CPU-
// priority instance (index 1) share stimulus, each with its own RAM model.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_address;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_read;
  logic [11:0] host_address;
  logic        host_write;
  logic [31:0] host_writedata;
  logic        host_read;

  logic [31:0] cpu_rdata  [2];
  logic [31:0] host_rdata [2];
  logic        cpu_wait   [2];
  logic        host_wait  [2];
  logic        wren       [2];
  logic [3:0]  byteena    [2];
  logic [11:0] wraddr     [2];
  logic [31:0] wdata      [2];
  logic [11:0] rdaddr     [2];
  logic [31:0] q          [2];
  logic [31:0] ram        [2][4096];

  int checks = 0;
  int errors = 0;

  logic [31:0] cq0[$];
  logic [31:0] cq1[$];
  logic [31:0] hq0[$];
  logic [31:0] hq1[$];

  dmem_arbiter #(.ADDR_WIDTH(12), .FIXED_CPU_PRI(1'b0)) u_dut_rr (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_writedata(cpu_writedata),
    .cpu_byteenable(cpu_byteenable), .cpu_read(cpu_read), .cpu_readdata(cpu_rdata[0]),
    .cpu_waitrequest(cpu_wait[0]),
    .host_address(host_address), .host_write(host_write), .host_writedata(host_writedata),
    .host_read(host_read), .host_readdata(host_rdata[0]), .host_waitrequest(host_wait[0]),
    .mem_wren(wren[0]), .mem_byteena(byteena[0]), .mem_wraddress(wraddr[0]),
    .mem_data(wdata[0]), .mem_rdaddress(rdaddr[0]), .mem_q(q[0])
  );

  dmem_arbiter #(.ADDR_WIDTH(12), .FIXED_CPU_PRI(1'b1)) u_dut_fix (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_write(cpu_write), .cpu_writedata(cpu_writedata),
    .cpu_byteenable(cpu_byteenable), .cpu_read(cpu_read), .cpu_readdata(cpu_rdata[1]),
    .cpu_waitrequest(cpu_wait[1]),
    .host_address(host_address), .host_write(host_write), .host_writedata(host_writedata),
    .host_read(host_read), .host_readdata(host_rdata[1]), .host_waitrequest(host_wait[1]),
    .mem_wren(wren[1]), .mem_byteena(byteena[1]), .mem_wraddress(wraddr[1]),
    .mem_data(wdata[1]), .mem_rdaddress(rdaddr[1]), .mem_q(q[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: byte-lane writes, registered read returning old data.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      q[d] <= ram[d][rdaddr[d]];
      if (wren[d]) begin
        for (int b = 0; b < 4; b++) begin
          if (byteena[d][b]) ram[d][wraddr[d]][8*b +: 8] = wdata[d][8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic chk1(input int d, input string tag, input logic obs, input logic exp);
    chk(d, tag, 32'(obs), 32'(exp));
  endtask

  function automatic int qsize(input int d, input bit host);
    if (host) return (d == 0) ? hq0.size() : hq1.size();
    return (d == 0) ? cq0.size() : cq1.size();
  endfunction

  task automatic push(input bit host, input logic [31:0] ea, input logic [31:0] eb);
    if (host) begin
      hq0.push_back(ea);
      hq1.push_back(eb);
    end else begin
      cq0.push_back(ea);
      cq1.push_back(eb);
    end
  endtask

  // Pop the oldest expected read for this dut/port and compare.
  task automatic sb_pop(input int d, input bit host, input logic [31:0] obs);
    logic [31:0] exp;
    logic        have;
    exp  = 32'h0;
    have = 1'b0;
    if (qsize(d, host) > 0) begin
      have = 1'b1;
      if (host) exp = (d == 0) ? hq0.pop_front() : hq1.pop_front();
      else      exp = (d == 0) ? cq0.pop_front() : cq1.pop_front();
    end
    chk1(d, host ? "host_read_expected" : "cpu_read_expected", have, 1'b1);
    if (have) chk(d, host ? "host_readdata" : "cpu_readdata", obs, exp);
  endtask

  // Monitor: every completed read is checked against the scoreboard.
  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      if (cpu_read && !cpu_wait[d])   sb_pop(d, 1'b0, cpu_rdata[d]);
      if (host_read && !host_wait[d]) sb_pop(d, 1'b1, host_rdata[d]);
    end
  end

  task automatic clear_reqs();
    cpu_write  = 1'b0;
    cpu_read   = 1'b0;
    host_write = 1'b0;
    host_read  = 1'b0;
  endtask

  // Lone read: wait high in the first cycle, served in the second.
  task automatic rd(input bit host, input logic [31:0] addr, input logic [31:0] ea, input logic [31:0] eb);
    logic [11:0] word;
    @(negedge clk);
    clear_reqs();
    if (host) begin
      host_read    = 1'b1;
      host_address = addr[11:0];
      word         = addr[11:0];
    end else begin
      cpu_read    = 1'b1;
      cpu_address = addr;
      word        = addr[13:2];
    end
    push(host, ea, eb);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1(d, "rd_wait_first", host ? host_wait[d] : cpu_wait[d], 1'b1);
      chk(d, "rd_rdaddress", 32'(rdaddr[d]), 32'(word));
    end
    @(negedge clk);
    #3;
    for (int d = 0; d < 2; d++) chk(d, "rd_served_2nd", 32'(qsize(d, host)), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4096; i++) ram[d][i] = 32'h0;
    reset = 1'b1;
    clear_reqs();
    cpu_read       = 1'b1;
    cpu_address    = 32'h0;
    cpu_writedata  = 32'h0;
    cpu_byteenable = 4'h0;
    host_address   = 12'h0;
    host_writedata = 32'h0;

    // Reset held three cycles with a pending CPU read.
    repeat (3) begin
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk1(d, "rst_cpu_wait", cpu_wait[d], 1'b1);
        chk1(d, "rst_host_wait", host_wait[d], 1'b1);
        chk1(d, "rst_wren", wren[d], 1'b0);
        chk(d, "rst_cpu_rdata", cpu_rdata[d], 32'h0);
        chk(d, "rst_host_rdata", host_rdata[d], 32'h0);
        chk(d, "rst_rdaddr", 32'(rdaddr[d]), 32'h0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    clear_reqs();
    #1;
    for (int d = 0; d < 2; d++) chk1(d, "idle_cpu_wait", cpu_wait[d], 1'b1);

    // CPU partial write then read-back.
    @(negedge clk);
    cpu_write      = 1'b1;
    cpu_address    = 32'h10;
    cpu_writedata  = 32'hDEADBEEF;
    cpu_byteenable = 4'b0011;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1(d, "wr_wren", wren[d], 1'b1);
      chk(d, "wr_wraddr", 32'(wraddr[d]), 32'd4);
      chk(d, "wr_byteena", 32'(byteena[d]), 32'h3);
      chk(d, "wr_data", wdata[d], 32'hDEADBEEF);
      chk1(d, "wr_cpu_wait", cpu_wait[d], 1'b0);
      chk1(d, "wr_host_wait", host_wait[d], 1'b1);
    end
    rd(1'b0, 32'h10, 32'h0000BEEF, 32'h0000BEEF);

    // Host write to word 8, then reset so the CPU wins the next tie.
    @(negedge clk);
    clear_reqs();
    host_write     = 1'b1;
    host_address   = 12'd8;
    host_writedata = 32'h12345678;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1(d, "hwr_host_wait", host_wait[d], 1'b0);
      chk(d, "hwr_byteena", 32'(byteena[d]), 32'hF);
      chk(d, "hwr_wraddr", 32'(wraddr[d]), 32'd8);
    end
    @(negedge clk);
    clear_reqs();
    reset = 1'b1;

    // Simultaneous reads: CPU cycles 1-2, host cycles 3-4.
    @(negedge clk);
    reset        = 1'b0;
    cpu_read     = 1'b1;
    cpu_address  = 32'h10;
    host_read    = 1'b1;
    host_address = 12'd8;
    push(1'b0, 32'h0000BEEF, 32'h0000BEEF);
    push(1'b1, 32'h12345678, 32'h12345678);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1(d, "tie_c1_cpu_wait", cpu_wait[d], 1'b1);
      chk(d, "tie_c1_rdaddr", 32'(rdaddr[d]), 32'd4);
    end
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1(d, "tie_c2_host_wait", host_wait[d], 1'b1);
      chk(d, "tie_c2_host_rdata", host_rdata[d], 32'h0);
    end
    #2;
    for (int d = 0; d < 2; d++) chk(d, "tie_cpu_served", 32'(qsize(d, 1'b0)), 32'd0);
    cpu_read = 1'b0;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1(d, "tie_c3_host_wait", host_wait[d], 1'b1);
      chk(d, "tie_c3_rdaddr", 32'(rdaddr[d]), 32'd8);
    end
    @(negedge clk);
    #3;
    for (int d = 0; d < 2; d++) chk(d, "tie_host_served", 32'(qsize(d, 1'b1)), 32'd0);

    // Reset while in RD_HOST: read dropped, re-issued read completes.
    @(negedge clk);
    clear_reqs();
    host_read    = 1'b1;
    host_address = 12'd8;
    #1;
    for (int d = 0; d < 2; d++) chk1(d, "rr_host_wait", host_wait[d], 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1(d, "rmid_host_wait", host_wait[d], 1'b1);
      chk(d, "rmid_host_rdata", host_rdata[d], 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    push(1'b1, 32'h12345678, 32'h12345678);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1(d, "reissue_host_wait", host_wait[d], 1'b1);
      chk(d, "reissue_rdaddr", 32'(rdaddr[d]), 32'd8);
    end
    @(negedge clk);
    #3;
    for (int d = 0; d < 2; d++) chk(d, "reissue_served", 32'(qsize(d, 1'b1)), 32'd0);

    // Both writing continuously: RR alternates, fixed priority starves host.
    @(negedge clk);
    clear_reqs();
    reset = 1'b1;
    @(negedge clk);
    reset          = 1'b0;
    host_write     = 1'b1;
    cpu_address    = 32'h40;
    host_address   = 12'd20;
    cpu_byteenable = 4'hF;
    for (int k = 0; k < 7; k++) begin
      logic cw0, cw1;
      if (k > 0) @(negedge clk);
      cpu_write      = (k < 6);
      cpu_writedata  = 32'hC000_0000 | 32'(k);
      host_writedata = 32'hA000_0000 | 32'(k);
      #1;
      cw0 = (k < 6) && (k % 2 == 0);
      cw1 = (k < 6);
      chk1(0, "cont_cpu_wait", cpu_wait[0], !cw0);
      chk1(0, "cont_host_wait", host_wait[0], cw0);
      chk(0, "cont_wraddr", 32'(wraddr[0]), cw0 ? 32'd16 : 32'd20);
      chk(0, "cont_wdata", wdata[0], cw0 ? cpu_writedata : host_writedata);
      chk1(1, "cont_cpu_wait", cpu_wait[1], !cw1);
      chk1(1, "cont_host_wait", host_wait[1], cw1);
      chk(1, "cont_wraddr", 32'(wraddr[1]), cw1 ? 32'd16 : 32'd20);
      chk(1, "cont_byteena", 32'(byteena[1]), cw1 ? 32'hF : 32'hF);
    end
    rd(1'b0, 32'h40, 32'hC000_0004, 32'hC000_0005);
    rd(1'b1, 32'd20, 32'hA000_0006, 32'hA000_0006);

    // Upper CPU address bits alias onto the same word.
    rd(1'b0, 32'h1000_0010, 32'h0000BEEF, 32'h0000BEEF);

    @(negedge clk);
    clear_reqs();
    repeat (2) @(negedge clk);
    #3;
    chk(0, "sb_drained", 32'(cq0.size() + cq1.size() + hq0.size() + hq1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
